// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C write sequencer: FSM states, direction bit
// and default sizing.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ST_REQ,
        ST_WAIT,
        ADDR_WAIT,
        LOAD,
        DATA_REQ,
        DATA_WAIT,
        SP_REQ,
        SP_WAIT,
        FINISH
    } seq_state_t;

    localparam logic WR_BIT        = 1'b0;
    localparam int   DEF_MAX_LEN   = 16;
    localparam int   DEF_TO_CYCLES = 4096;

endpackage

// File: rtl/i2c_write_seq_if.sv
// Command/stream/master-strobe bundle of the I2C write sequencer.
// slave = sequencer view, master = host and byte-level master view.
interface i2c_write_seq_if #(
    parameter int LEN_W = 5
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [6:0]       cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             wr_valid;
    logic             wr_ready;
    logic [7:0]       wr_data;
    logic             busy;
    logic             done;
    logic             err;
    logic             m_en;
    logic             m_start;
    logic             m_stop;
    logic [7:0]       m_tx_data;
    logic             m_ready;
    logic             m_tx_done;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data, m_ready, m_tx_done,
        output cmd_ready, wr_ready, busy, done, err, m_en, m_start, m_stop, m_tx_data
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, wr_valid, wr_data, m_ready, m_tx_done,
        input  cmd_ready, wr_ready, busy, done, err, m_en, m_start, m_stop, m_tx_data
    );
endinterface

// File: rtl/i2c_seq_edge.sv
// Two-phase m_ready tracker: rose fires once m_ready has been seen low and is
// high again while track is held; dropping track re-arms it.
module i2c_seq_edge (
    input  logic clk,
    input  logic reset,
    input  logic track,
    input  logic m_ready,
    output logic rose
);
    logic seen_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_fall <= 1'b0;
        end else if (!track) begin
            seen_fall <= 1'b0;
        end else if (!m_ready) begin
            seen_fall <= 1'b1;
        end
    end

    always_comb rose = track && seen_fall && m_ready;
endmodule

// File: rtl/i2c_write_seq.sv
// I2C write transaction sequencer: START, {addr,0}, N data bytes, STOP.
// Optional watchdog enabled by defining I2C_SEQ_TIMEOUT_EN.
module i2c_write_seq
    import i2c_pkg::*;
#(
    parameter int MAX_LEN   = DEF_MAX_LEN,
    parameter int LEN_W     = 5,
    parameter int TO_CYCLES = DEF_TO_CYCLES
) (
    input logic            clk,
    input logic            reset,
    i2c_write_seq_if.slave bus
);
    if ((2 ** LEN_W) <= MAX_LEN || MAX_LEN < 1 || TO_CYCLES < 1) begin : g_bad_cfg
        $error("i2c_write_seq: invalid MAX_LEN/LEN_W/TO_CYCLES combination");
    end

    seq_state_t       state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] eff_len;
    logic             len_over;
    logic             rose;
    logic             timeout;

    always_comb begin
        len_over = bus.cmd_len > LEN_W'(MAX_LEN);
        eff_len  = bus.cmd_len;
        if (bus.cmd_len == '0) begin
            eff_len = LEN_W'(1);
        end else if (len_over) begin
            eff_len = LEN_W'(MAX_LEN);
        end
    end

    i2c_seq_edge u_edge (
        .clk    (clk),
        .reset  (reset),
        .track  (state == ST_WAIT || state == SP_WAIT),
        .m_ready(bus.m_ready),
        .rose   (rose)
    );

`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TO_CYCLES + 1);

    seq_state_t      prev_state;
    logic [WD_W-1:0] wd;

    // Watchdog restarts whenever the state register changes value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_state <= IDLE;
            wd         <= '0;
        end else begin
            prev_state <= state;
            if (state != prev_state || state == IDLE) begin
                wd <= '0;
            end else if (wd != WD_W'(TO_CYCLES)) begin
                wd <= wd + WD_W'(1);
            end
        end
    end

    always_comb timeout = (wd == WD_W'(TO_CYCLES)) && state != IDLE && state != FINISH;
`else
    always_comb timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            len           <= '0;
            cnt           <= '0;
            bus.cmd_ready <= 1'b1;
            bus.wr_ready  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.m_en      <= 1'b0;
            bus.m_start   <= 1'b0;
            bus.m_stop    <= 1'b0;
            bus.m_tx_data <= 8'h00;
        end else begin
            bus.m_start  <= 1'b0;
            bus.m_stop   <= 1'b0;
            bus.wr_ready <= 1'b0;
            bus.done     <= 1'b0;
            if (bus.m_tx_done && state != ADDR_WAIT && state != DATA_WAIT) begin
                bus.err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        bus.m_en      <= 1'b1;
                        bus.err       <= len_over;
                        bus.m_tx_data <= {bus.cmd_addr, WR_BIT};
                        len           <= eff_len;
                        cnt           <= '0;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.m_ready) begin
                        bus.m_start <= 1'b1;
                        state       <= ST_WAIT;
                    end
                end
                ST_WAIT: if (rose) state <= ADDR_WAIT;
                ADDR_WAIT: if (bus.m_tx_done) state <= LOAD;
                LOAD: begin
                    if (bus.wr_valid) begin
                        bus.m_tx_data <= bus.wr_data;
                        bus.wr_ready  <= 1'b1;
                        cnt           <= cnt + LEN_W'(1);
                        state         <= DATA_REQ;
                    end
                end
                DATA_REQ: begin
                    if (bus.m_ready) begin
                        bus.m_start <= 1'b1;
                        state       <= DATA_WAIT;
                    end
                end
                DATA_WAIT: begin
                    if (bus.m_tx_done) state <= (cnt == len) ? SP_REQ : LOAD;
                end
                SP_REQ: begin
                    if (bus.m_ready) begin
                        bus.m_stop <= 1'b1;
                        state      <= SP_WAIT;
                    end
                end
                SP_WAIT: begin
                    if (rose) begin
                        bus.done <= 1'b1;
                        bus.m_en <= 1'b0;
                        state    <= FINISH;
                    end
                end
                FINISH: begin
                    bus.cmd_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // Watchdog abort overrides whatever the state decided this cycle.
            if (timeout) begin
                bus.err     <= 1'b1;
                bus.m_start <= 1'b0;
                bus.m_stop  <= 1'b1;
                bus.done    <= 1'b1;
                bus.m_en    <= 1'b0;
                state       <= FINISH;
            end
        end
    end
endmodule

// File: tb/tb_i2c_write_seq.sv
// Scoreboard bench for i2c_write_seq with a behavioural byte-level master.
// Define I2C_SEQ_TIMEOUT_EN to also exercise the watchdog (TO_CYCLES=64).
module tb_i2c_write_seq;
    import i2c_pkg::*;

    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
`ifdef I2C_SEQ_TIMEOUT_EN
    localparam int TO_CYCLES = 64;
`else
    localparam int TO_CYCLES = 4096;
`endif

    typedef enum int {M_IDLE, M_START, M_ADDR, M_BYTE, M_STOP} mst_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    i2c_write_seq_if #(.LEN_W(LEN_W)) bus ();

    i2c_write_seq #(
        .MAX_LEN  (MAX_LEN),
        .LEN_W    (LEN_W),
        .TO_CYCLES(TO_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int starts = 0, stops = 0, dones = 0, txdones = 0;
    int overlap = 0, wide = 0, held = 0;
    logic prev_start = 1'b0;
    logic hold_low = 1'b0, model_ready = 1'b1, stuck = 1'b0;
    mst_t ms = M_IDLE;
    logic [7:0] exp_q[$];
    logic [7:0] data_buf[$];

    assign bus.m_ready = model_ready & ~hold_low;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_start = 1'b0;
        end else begin
            if (bus.m_start) starts++;
            if (bus.m_stop) stops++;
            if (bus.done) dones++;
            if (bus.m_start && bus.m_stop) overlap++;
            if (bus.m_start && prev_start) wide++;
            if (bus.m_start && hold_low) held++;
            prev_start = bus.m_start;
        end
    end

    task automatic finish_byte();
        logic [7:0] e;
        bus.m_tx_done = 1'b1;
        txdones++;
        check("sb_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("tx_byte", bus.m_tx_data, e);
        end
    endtask

    // Byte-level master: START/STOP drop m_ready for 3 cycles, bytes take 6.
    initial begin : master_model
        int t;
        bit in_txn;
        t = 0;
        in_txn = 1'b0;
        bus.m_tx_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.m_tx_done = 1'b0;
            if (reset) begin
                ms = M_IDLE;
                model_ready = 1'b1;
                in_txn = 1'b0;
            end else begin
                case (ms)
                    M_IDLE: begin
                        if (bus.m_start && !in_txn) begin
                            ms = M_START; t = 3; model_ready = 1'b0;
                        end else if (bus.m_start) begin
                            ms = M_BYTE; t = 6; model_ready = 1'b0;
                        end else if (bus.m_stop) begin
                            ms = M_STOP; t = 3; model_ready = 1'b0;
                        end
                    end
                    M_START: begin
                        t--;
                        if (t == 0) begin model_ready = 1'b1; ms = M_ADDR; t = 4; end
                    end
                    M_ADDR: begin
                        t--;
                        if (t == 0) begin finish_byte(); in_txn = 1'b1; ms = M_IDLE; end
                    end
                    M_BYTE: begin
                        if (!stuck) begin
                            t--;
                            if (t == 0) begin finish_byte(); model_ready = 1'b1; ms = M_IDLE; end
                        end
                    end
                    M_STOP: begin
                        t--;
                        if (t == 0) begin model_ready = 1'b1; in_txn = 1'b0; ms = M_IDLE; end
                    end
                    default: ms = M_IDLE;
                endcase
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "_wr_ready"}, bus.wr_ready, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err"}, bus.err, 0);
        check({tag, "_m_en"}, bus.m_en, 0);
        check({tag, "_m_start"}, bus.m_start, 0);
        check({tag, "_m_stop"}, bus.m_stop, 0);
        check({tag, "_m_tx_data"}, bus.m_tx_data, 8'h00);
    endtask

    task automatic issue_cmd(input logic [6:0] a, input logic [LEN_W-1:0] l);
        int k;
        k = 0;
        while (!bus.cmd_ready && k < 100) begin cyc(1); k++; end
        check("cmd_ready_wait", bus.cmd_ready, 1);
        exp_q.push_back({a, 1'b0});
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        bus.cmd_valid = 1'b1;
        cyc(1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        int k;
        k = 0;
        exp_q.push_back(b);
        bus.wr_data  = b;
        bus.wr_valid = 1'b1;
        do begin cyc(1); k++; end while (!bus.wr_ready && k < 300);
        check("wr_ready_seen", bus.wr_ready, 1);
        bus.wr_valid = 1'b0;
    endtask

    task automatic wait_tx(input int target);
        int k;
        k = 0;
        while (txdones < target && k < 300) begin cyc(1); k++; end
        check("tx_progress", txdones >= target, 1);
    endtask

    task automatic run_txn(input string tag, input logic [6:0] a, input logic [LEN_W-1:0] l,
                           input int nbytes, input int stall_idx, input int hold_idx,
                           input bit hold_st, input logic exp_err);
        int s0, p0, d0, t0, k;
        s0 = starts; p0 = stops; d0 = dones; t0 = txdones;
        if (hold_st) hold_low = 1'b1;
        issue_cmd(a, l);
        if (hold_st) begin
            k = starts;
            cyc(50);
            check({tag, "_st_held_no_start"}, starts - k, 0);
            hold_low = 1'b0;
        end
        for (int i = 0; i < nbytes; i++) begin
            if (i == stall_idx) begin
                wait_tx(t0 + 1 + i);
                k = starts;
                cyc(200);
                check({tag, "_stall_no_start"}, starts - k, 0);
                check({tag, "_stall_data"}, bus.m_tx_data, data_buf[i-1]);
                check({tag, "_stall_busy"}, bus.busy, 1);
            end
            drive_byte(data_buf[i]);
            if (i == hold_idx) begin
                hold_low = 1'b1;
                k = starts;
                cyc(50);
                check({tag, "_data_held_no_start"}, starts - k, 0);
                hold_low = 1'b0;
            end
        end
        k = 0;
        while (dones == d0 && k < 400) begin cyc(1); k++; end
        check({tag, "_done_once"}, dones - d0, 1);
        check({tag, "_starts"}, starts - s0, nbytes + 1);
        check({tag, "_stops"}, stops - p0, 1);
        check({tag, "_bytes"}, txdones - t0, nbytes + 1);
        check({tag, "_err"}, bus.err, exp_err);
        check({tag, "_sb_drained"}, exp_q.size(), 0);
        cyc(1);
        check({tag, "_idle_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "_idle_busy"}, bus.busy, 0);
    endtask

    task automatic fill_random(input int n);
        data_buf.delete();
        for (int i = 0; i < n; i++) data_buf.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int k, d0, p0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_vals("rst_hold");
        reset = 1'b0;
        cyc(2);
        check_reset_vals("rst_idle");

        data_buf = '{8'hA5, 8'h5A};
        run_txn("basic", 7'h3C, 2, 2, -1, -1, 1'b0, 1'b0);

        fill_random(3);
        run_txn("stall", 7'h51, 3, 3, 1, -1, 1'b0, 1'b0);

        fill_random(2);
        run_txn("hold", 7'h12, 2, 2, -1, 0, 1'b1, 1'b0);

        fill_random(MAX_LEN);
        run_txn("clamp", 7'h7F, LEN_W'(MAX_LEN + 3), MAX_LEN, -1, -1, 1'b0, 1'b1);

        fill_random(1);
        run_txn("len0", 7'h00, 0, 1, -1, -1, 1'b0, 1'b0);

        issue_cmd(7'h11, 3);
        drive_byte(8'hC3);
        k = 0;
        while (ms != M_BYTE && k < 100) begin cyc(1); k++; end
        check("rst_mid_in_data_wait", ms == M_BYTE, 1);
        reset = 1'b1;
        cyc(1);
        check_reset_vals("rst_mid");
        exp_q.delete();
        reset = 1'b0;
        cyc(2);

        fill_random(4);
        run_txn("post_rst", 7'h2D, 4, 4, -1, -1, 1'b0, 1'b0);

`ifdef I2C_SEQ_TIMEOUT_EN
        stuck = 1'b1;
        d0 = dones;
        p0 = stops;
        issue_cmd(7'h2A, 1);
        drive_byte(8'h96);
        k = 0;
        while (ms != M_BYTE && k < 100) begin cyc(1); k++; end
        check("to_in_data_wait", ms == M_BYTE, 1);
        k = 0;
        while (dones == d0 && k < 200) begin cyc(1); k++; end
        check("to_done", dones - d0, 1);
        check("to_latency_window", k >= 60 && k <= 72, 1);
        check("to_err", bus.err, 1);
        check("to_one_stop", stops - p0, 1);
        cyc(1);
        check("to_idle_cmd_ready", bus.cmd_ready, 1);
        stuck = 1'b0;
        reset = 1'b1;
        cyc(1);
        exp_q.delete();
        reset = 1'b0;
        cyc(2);
`endif

        check("start_stop_overlap", overlap, 0);
        check("start_width_1", wide, 0);
        check("start_while_held", held, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
